// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two Half_Adder cells,
// a carry flop closing the loop, operands consumed LSB-first one bit per clock.

module Half_Adder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);
    assign Sum   = A ^ B;
    assign Carry = A & B;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_In,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_Out,
    output logic             dbg_state
);
    // Counter must hold WIDTH-1; keep at least one bit so WIDTH=1 still elaborates.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             last_bit;

    logic             ha0_sum;
    logic             ha0_carry;
    logic             ha1_sum;
    logic             ha1_carry;
    logic             slice_sum;
    logic             slice_carry;

    // Full-adder slice: (a ^ b) ^ cin, carry = (a & b) | ((a ^ b) & cin).
    Half_Adder u_ha0 (
        .A     (op_a_q[0]),
        .B     (op_b_q[0]),
        .Sum   (ha0_sum),
        .Carry (ha0_carry)
    );

    Half_Adder u_ha1 (
        .A     (ha0_sum),
        .B     (carry_q),
        .Sum   (ha1_sum),
        .Carry (ha1_carry)
    );

    assign slice_sum   = ha1_sum;
    assign slice_carry = ha0_carry | ha1_carry;

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
    assign psum_next = (psum_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE:    load = Start;
            RUN: begin
                step   = 1'b1;
                finish = last_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                op_a_q  <= A;
                op_b_q  <= B;
                carry_q <= Carry_In;
                psum_q  <= '0;
                cnt_q   <= '0;
            end else if (step) begin
                op_a_q  <= op_a_q >> 1;
                op_b_q  <= op_b_q >> 1;
                carry_q <= slice_carry;
                psum_q  <= psum_next;
                cnt_q   <= cnt_q + CW'(1);
            end
            // Result registers move only on the final bit, never showing partial sums.
            if (finish) begin
                sum_q  <= psum_next;
                cout_q <= slice_carry;
            end
        end
    end

    assign Busy      = (state_q == RUN);
    assign Done      = done_q;
    assign Sum       = sum_q;
    assign Carry_Out = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8 and WIDTH=1) against an
// arithmetic reference: {Carry_Out, Sum} = A + B + Carry_In.

module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=8 instance
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ci8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic       dbg8;

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       ci1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       dbg1;

    serial_adder #(.WIDTH(8)) dut8 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Start     (start8),
        .A         (a8),
        .B         (b8),
        .Carry_In  (ci8),
        .Busy      (busy8),
        .Done      (done8),
        .Sum       (sum8),
        .Carry_Out (cout8),
        .dbg_state (dbg8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Start     (start1),
        .A         (a1),
        .B         (b1),
        .Carry_In  (ci1),
        .Busy      (busy1),
        .Done      (done1),
        .Sum       (sum1),
        .Carry_Out (cout1),
        .dbg_state (dbg1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    function automatic logic [8:0] ref_add8(input int a, input int b, input int ci);
        int total;
        total = a + b + ci;
        return 9'(total % 512);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for Done on the 8-bit instance; returns edges waited (40 = timeout).
    task automatic wait_done8(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done8 && n < 40);
    endtask

    // ---------------- driver ----------------
    task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
        int lat;
        logic [8:0] exp;
        a8 = a;
        b8 = b;
        ci8 = ci;
        start8 = 1'b1;
        exp_q.push_back(ref_add8(int'(a), int'(b), int'(ci)));
        tick();
        start8 = 1'b0;
        // Operand changes after acceptance must not matter.
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        ci8 = 1'($urandom);
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        exp = exp_q.pop_front();
        check({tag, "_result"}, 32'({cout8, sum8}), 32'(exp));
        check({tag, "_idle"}, 32'(busy8), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int cnt;
        int exp1;
        logic [8:0] exp;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (3) tick();

        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_res8", 32'({cout8, sum8}), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_res1", 32'({cout1, sum1, done1}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic addition, single Done pulse, held result
        add8("a5a_3c", 8'h5a, 8'h3c, 1'b0);
        check("a5a_3c_sum", 32'(sum8), 32'h96);
        tick();
        check("done_single_pulse", 32'(done8), 32'd0);
        repeat (5) tick();
        check("sum_held", 32'({cout8, sum8}), 32'h096);

        add8("ff_01", 8'hff, 8'h01, 1'b0);
        add8("ff_ff_c1", 8'hff, 8'hff, 1'b1);

        // Start re-pulsed mid-run is ignored
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
        exp_q.push_back(ref_add8(16, 32, 0));
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        a8 = 8'hff; b8 = 8'hff; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(lat);
        check("restart_latency", 32'(lat + 3), 32'd8);
        exp = exp_q.pop_front();
        check("restart_result", 32'({cout8, sum8}), 32'(exp));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) cnt++;
        end
        check("restart_no_second_done", 32'(cnt), 32'd0);

        // Start held high: next operand set accepted on the edge after the Done cycle
        a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; start8 = 1'b1;
        exp_q.push_back(ref_add8(1, 2, 0));
        tick();
        a8 = 8'h80; b8 = 8'h80;
        exp_q.push_back(ref_add8(128, 128, 0));
        wait_done8(lat);
        check("b2b_first_latency", 32'(lat), 32'd8);
        exp = exp_q.pop_front();
        check("b2b_first_result", 32'({cout8, sum8}), 32'(exp));
        tick();
        check("b2b_second_accept_busy", 32'(busy8), 32'd1);
        start8 = 1'b0;
        wait_done8(lat);
        check("b2b_period", 32'(lat + 1), 32'd9);
        exp = exp_q.pop_front();
        check("b2b_second_result", 32'({cout8, sum8}), 32'(exp));

        // Reset mid-run aborts
        add8("pre_abort", 8'h5a, 8'h3c, 1'b0);
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_result", 32'({cout8, sum8}), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        add8("post_abort", 8'h12, 8'h34, 1'b0);

        // Random operands
        for (int i = 0; i < 16; i++) begin
            add8("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        // WIDTH=1: full-adder truth table, Done one cycle after accept
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2);
            b1 = 1'(i >> 1);
            ci1 = 1'(i);
            exp1 = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            tick();
            check("w1_done", 32'(done1), 32'd1);
            check("w1_result", 32'({cout1, sum1}), 32'(exp1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
